// File: rtl/trb_mem_arbiter_pkg.sv
// Purpose : shared types and defaults for the trace-buffer RAM arbiter.
// Contents: arbiter state/owner enums and default geometry of the trace RAM.
package trb_mem_arbiter_pkg;

   localparam int TRB_WIDTH_DEF    = 64;
   localparam int TRB_DEPTH_DEF    = 64;
   localparam int TRB_ADDR_BITS    = $clog2(TRB_DEPTH_DEF);
   localparam int MAX_LOG_WAIT_DEF = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_RSP} arb_state_t;
   typedef enum logic       {OWN_LOG, OWN_HOST}       arb_owner_t;

endpackage

// File: rtl/trb_mem_arbiter_rr_pick2.sv
// Purpose : combinational two-way round-robin selector (logger vs host).
// Ports   : req_log, req_host  - eligible requests this cycle
//           last_is_host       - previous grant went to the host
//           grant              - at least one request is eligible
//           pick_host          - 1 = host wins, 0 = logger wins (valid with grant)
module rr_pick2 (
   input  logic req_log,
   input  logic req_host,
   input  logic last_is_host,
   output logic grant,
   output logic pick_host
);

   always_comb begin
      grant     = req_log | req_host;
      // on a tie the side that was not served last wins
      pick_host = req_host & (~req_log | ~last_is_host);
   end

endmodule

// File: rtl/trb_mem_arbiter.sv
// Purpose : sole owner of the single-port trace-buffer RAM; shares it between
//           the trace logger (write-new/return-old exchange) and the host
//           (single read or write). Each access takes ST_ACC then ST_RSP, the
//           response cycle strobes the owner with the RAM read data.
//           A sticky flag reports logger starvation (real-time trace loss).
// Ports   : CLK_I, RST_NI (async, active low)
//           LOG_RW_I/LOG_PTR_I/LOG_DATA_I  -> LOG_RW_TURN_O/LOG_DATA_O
//           HOST_REQ_I/HOST_WE_I/HOST_PTR_I/HOST_DATA_I -> HOST_ACK_O/HOST_DATA_O
//           CLR_I -> LOG_OVERRUN_O
//           MEM_EN_O/MEM_WE_O/MEM_ADDR_O/MEM_WDATA_O, MEM_RDATA_I (read-first, 1-cycle)
//
// state   | meaning
// ST_IDLE | no access in flight, arbitrate raw requests
// ST_ACC  | RAM enabled with the registered command
// ST_RSP  | read data back from RAM, strobe owner, arbitrate the other side
module trb_mem_arbiter
   import trb_mem_arbiter_pkg::*;
#(
   parameter int TRB_WIDTH    = TRB_WIDTH_DEF,
   parameter int TRB_DEPTH    = TRB_DEPTH_DEF,
   parameter int MAX_LOG_WAIT = MAX_LOG_WAIT_DEF
) (
   input  logic                         CLK_I,
   input  logic                         RST_NI,
   input  logic                         LOG_RW_I,
   input  logic [$clog2(TRB_DEPTH)-1:0] LOG_PTR_I,
   input  logic [TRB_WIDTH-1:0]         LOG_DATA_I,
   output logic                         LOG_RW_TURN_O,
   output logic [TRB_WIDTH-1:0]         LOG_DATA_O,
   input  logic                         HOST_REQ_I,
   input  logic                         HOST_WE_I,
   input  logic [$clog2(TRB_DEPTH)-1:0] HOST_PTR_I,
   input  logic [TRB_WIDTH-1:0]         HOST_DATA_I,
   output logic                         HOST_ACK_O,
   output logic [TRB_WIDTH-1:0]         HOST_DATA_O,
   input  logic                         CLR_I,
   output logic                         LOG_OVERRUN_O,
   output logic                         MEM_EN_O,
   output logic                         MEM_WE_O,
   output logic [$clog2(TRB_DEPTH)-1:0] MEM_ADDR_O,
   output logic [TRB_WIDTH-1:0]         MEM_WDATA_O,
   input  logic [TRB_WIDTH-1:0]         MEM_RDATA_I
);

   localparam int AW = $clog2(TRB_DEPTH);
   localparam int CW = $clog2(MAX_LOG_WAIT + 2);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOG_WAIT);
   localparam logic [CW-1:0] CNT_SAT = CW'(MAX_LOG_WAIT + 1);

   arb_state_t           state;
   arb_owner_t           owner;
   arb_owner_t           last_grant;
   logic [AW-1:0]        cmd_addr;
   logic                 cmd_we;
   logic [TRB_WIDTH-1:0] cmd_wdata;
   logic                 mem_en_q;
   logic                 log_turn_q;
   logic                 host_ack_q;
   logic [CW-1:0]        wait_cnt;
   logic                 overrun_q;

   logic                 req_log_eff;
   logic                 req_host_eff;
   logic                 grant;
   logic                 pick_host;

   // the owner being acked in ST_RSP is excluded so it cannot re-win back to back
   always_comb begin
      req_log_eff  = LOG_RW_I   && (state != ST_ACC) &&
                     !(state == ST_RSP && owner == OWN_LOG);
      req_host_eff = HOST_REQ_I && (state != ST_ACC) &&
                     !(state == ST_RSP && owner == OWN_HOST);
   end

   rr_pick2 u_pick (
      .req_log      (req_log_eff),
      .req_host     (req_host_eff),
      .last_is_host (last_grant == OWN_HOST),
      .grant        (grant),
      .pick_host    (pick_host)
   );

   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         state      <= ST_IDLE;
         owner      <= OWN_LOG;
         last_grant <= OWN_HOST;
         cmd_addr   <= '0;
         cmd_we     <= 1'b0;
         cmd_wdata  <= '0;
         mem_en_q   <= 1'b0;
         log_turn_q <= 1'b0;
         host_ack_q <= 1'b0;
         wait_cnt   <= '0;
         overrun_q  <= 1'b0;
      end else begin
         mem_en_q   <= 1'b0;
         log_turn_q <= 1'b0;
         host_ack_q <= 1'b0;
         case (state)
            ST_IDLE, ST_RSP: begin
               if (state == ST_RSP) last_grant <= owner;
               if (grant) begin
                  owner     <= pick_host ? OWN_HOST : OWN_LOG;
                  cmd_addr  <= pick_host ? HOST_PTR_I : LOG_PTR_I;
                  cmd_we    <= pick_host ? HOST_WE_I : 1'b1;
                  cmd_wdata <= pick_host ? HOST_DATA_I : LOG_DATA_I;
                  mem_en_q  <= 1'b1;
                  state     <= ST_ACC;
               end else begin
                  state     <= ST_IDLE;
               end
            end
            ST_ACC: begin
               state      <= ST_RSP;
               log_turn_q <= (owner == OWN_LOG);
               host_ack_q <= (owner == OWN_HOST);
            end
            default: state <= ST_IDLE;
         endcase

         // log_turn_q is high exactly in ST_RSP with the logger as owner
         if (log_turn_q)
            wait_cnt <= '0;
         else if (LOG_RW_I && wait_cnt != CNT_SAT)
            wait_cnt <= wait_cnt + 1'b1;

         if (wait_cnt > CNT_MAX)
            overrun_q <= 1'b1;
         else if (CLR_I)
            overrun_q <= 1'b0;
      end
   end

   always_comb begin
      MEM_EN_O      = mem_en_q;
      MEM_WE_O      = mem_en_q & cmd_we;
      MEM_ADDR_O    = mem_en_q ? cmd_addr : '0;
      MEM_WDATA_O   = mem_en_q ? cmd_wdata : '0;
      LOG_RW_TURN_O = log_turn_q;
      HOST_ACK_O    = host_ack_q;
      LOG_DATA_O    = log_turn_q ? MEM_RDATA_I : '0;
      HOST_DATA_O   = host_ack_q ? MEM_RDATA_I : '0;
      LOG_OVERRUN_O = overrun_q;
   end

endmodule

// File: tb/tb_trb_mem_arbiter.sv
module tb_trb_mem_arbiter;
   import trb_mem_arbiter_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     log_rw, host_req, host_we, clr;
   logic [TRB_ADDR_BITS-1:0] log_ptr, host_ptr;
   logic [63:0]              log_data, host_data;
   logic                     turn, ack, ov, men, mwe;
   logic [63:0]              ldata, hdata, mwdata, mrdata;
   logic [TRB_ADDR_BITS-1:0] maddr;

   // second instance with a tight starvation limit
   logic                     l2_rw, h2_req, clr2;
   logic                     t2_turn, t2_ack, ov2, m2_en, m2_we;
   logic [63:0]              t2_ldata, t2_hdata, m2_wdata;
   logic [TRB_ADDR_BITS-1:0] m2_addr;

   logic [63:0] ram [64];
   logic [63:0] ref_mem [64];
   logic        preload;
   logic [63:0] exp_log[$];
   logic [63:0] exp_host[$];
   int          cyc;
   int          n_chk, n_pass;
   int          last_log, last_host, glog, ghost, n_acks;
   logic        gap_en, gap_en_q;
   logic        any_out;

   always #5 clk = ~clk;

   trb_mem_arbiter dut (
      .CLK_I(clk), .RST_NI(rst_n),
      .LOG_RW_I(log_rw), .LOG_PTR_I(log_ptr), .LOG_DATA_I(log_data),
      .LOG_RW_TURN_O(turn), .LOG_DATA_O(ldata),
      .HOST_REQ_I(host_req), .HOST_WE_I(host_we), .HOST_PTR_I(host_ptr),
      .HOST_DATA_I(host_data), .HOST_ACK_O(ack), .HOST_DATA_O(hdata),
      .CLR_I(clr), .LOG_OVERRUN_O(ov),
      .MEM_EN_O(men), .MEM_WE_O(mwe), .MEM_ADDR_O(maddr),
      .MEM_WDATA_O(mwdata), .MEM_RDATA_I(mrdata)
   );

   trb_mem_arbiter #(.TRB_WIDTH(64), .TRB_DEPTH(64), .MAX_LOG_WAIT(2)) dut2 (
      .CLK_I(clk), .RST_NI(rst_n),
      .LOG_RW_I(l2_rw), .LOG_PTR_I(6'd0), .LOG_DATA_I(64'd0),
      .LOG_RW_TURN_O(t2_turn), .LOG_DATA_O(t2_ldata),
      .HOST_REQ_I(h2_req), .HOST_WE_I(1'b0), .HOST_PTR_I(6'd0),
      .HOST_DATA_I(64'd0), .HOST_ACK_O(t2_ack), .HOST_DATA_O(t2_hdata),
      .CLR_I(clr2), .LOG_OVERRUN_O(ov2),
      .MEM_EN_O(m2_en), .MEM_WE_O(m2_we), .MEM_ADDR_O(m2_addr),
      .MEM_WDATA_O(m2_wdata), .MEM_RDATA_I(64'd0)
   );

   function automatic logic [63:0] pat(input int i);
      return 64'hA5A5_0000_0000_0000 | 64'(i);
   endfunction

   // read-first RAM, 1-cycle latency
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 64; i++) ram[i] <= pat(i);
         ram[5] <= 64'hAA;
      end else if (men) begin
         mrdata <= ram[maddr];
         if (mwe) ram[maddr] <= mwdata;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   assign any_out = turn | (|ldata) | ack | (|hdata) | ov | men | mwe | (|maddr) | (|mwdata)
                  | t2_turn | (|t2_ldata) | t2_ack | (|t2_hdata) | ov2 | m2_en | m2_we
                  | (|m2_addr) | (|m2_wdata);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (gap_en && !gap_en_q) begin glog = -1; ghost = -1; end
      gap_en_q = gap_en;
      if (turn) begin
         if (exp_log.size() == 0) chk("log_unexpected_strobe", 64'd1, 64'd0);
         else chk("log_data", ldata, exp_log.pop_front());
         if (gap_en && glog >= 0) chk("log_gap_le4", 64'(cyc - glog <= 4), 64'd1);
         glog = cyc; last_log = cyc;
      end else chk("log_data_zero", ldata, 64'd0);
      if (ack) begin
         n_acks++;
         if (exp_host.size() == 0) chk("host_unexpected_strobe", 64'd1, 64'd0);
         else chk("host_data", hdata, exp_host.pop_front());
         if (gap_en && ghost >= 0) chk("host_gap_le4", 64'(cyc - ghost <= 4), 64'd1);
         ghost = cyc; last_host = cyc;
      end else chk("host_data_zero", hdata, 64'd0);
   end

   task automatic do_log(input logic [5:0] a, input logic [63:0] d);
      int n = 0;
      exp_log.push_back(ref_mem[a]);
      ref_mem[a] = d;
      log_rw = 1'b1; log_ptr = a; log_data = d;
      do begin @(negedge clk); n++; end while (!turn && n < 50);
      chk("log_handshake", 64'(turn), 64'd1);
      @(posedge clk); #1;
      log_rw = 1'b0;
   endtask

   task automatic do_host(input logic we, input logic [5:0] a, input logic [63:0] d);
      int n = 0;
      exp_host.push_back(ref_mem[a]);
      if (we) ref_mem[a] = d;
      host_req = 1'b1; host_we = we; host_ptr = a; host_data = d;
      do begin @(negedge clk); n++; end while (!ack && n < 50);
      chk("host_handshake", 64'(ack), 64'd1);
      @(posedge clk); #1;
      host_req = 1'b0;
   endtask

   // host wins the first access, logger then waits ACC+RSP+ACC on dut2
   task automatic starve2(input logic clr_at_turn);
      @(posedge clk); #1; h2_req = 1'b1;
      @(posedge clk); #1; l2_rw = 1'b1;
      @(posedge clk); #1; h2_req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1; clr2 = clr_at_turn;
      @(negedge clk);
      chk("ov2_turn", 64'(t2_turn), 64'd1);
      chk("ov2_before_set", 64'(ov2), 64'd0);
      @(posedge clk); #1; l2_rw = 1'b0; clr2 = 1'b0;
      @(negedge clk);
      chk(clr_at_turn ? "ov2_set_wins_over_clr" : "ov2_set", 64'(ov2), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int t0, acks0;
      rst_n = 1'b0; preload = 1'b1;
      log_rw = 0; host_req = 0; host_we = 0; clr = 0; log_ptr = 0; host_ptr = 0;
      log_data = 0; host_data = 0; l2_rw = 0; h2_req = 0; clr2 = 0;
      gap_en = 0; gap_en_q = 0; last_log = -1; last_host = -1; glog = -1; ghost = -1;
      for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
      ref_mem[5] = 64'hAA;

      // 1: reset, then idle
      repeat (4) @(posedge clk);
      @(negedge clk); chk("reset_outputs_zero", 64'(any_out), 64'd0);
      @(posedge clk); #1; rst_n = 1'b1; preload = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); chk("idle_outputs_zero", 64'(any_out), 64'd0);
      end
      @(posedge clk); #1;

      // 2: exchange at address 5, exact cycle timing
      fork
         do_log(6'd5, 64'h1234);
         begin
            @(negedge clk); chk("xchg_c0_mem_en", 64'(men), 64'd0);
            @(negedge clk);
            chk("xchg_c1_mem_en", 64'(men), 64'd1);
            chk("xchg_c1_mem_we", 64'(mwe), 64'd1);
            chk("xchg_c1_mem_addr", 64'(maddr), 64'd5);
            chk("xchg_c1_mem_wdata", mwdata, 64'h1234);
            @(negedge clk); chk("xchg_c2_turn", 64'(turn), 64'd1);
         end
      join
      do_host(1'b0, 6'd5, 64'd0);
      chk("ref_addr5_is_1234", ref_mem[5], 64'h1234);

      // 3: simultaneous requests, last grant = host -> logger first
      for (int r = 0; r < 2; r++) begin
         t0 = cyc;
         fork
            do_log(6'(10 + 2 * r), 64'h1111_0000 | 64'(r));
            do_host(1'b0, 6'(11 + 2 * r), 64'd0);
         join
         chk("tie_log_at_2", 64'(last_log - t0), 64'd2);
         chk("tie_host_at_4", 64'(last_host - t0), 64'd4);
      end
      // last grant = logger -> host wins the tie; host write returns old word
      do_log(6'd20, 64'h2020);
      t0 = cyc;
      fork
         do_log(6'd21, 64'h2121);
         do_host(1'b1, 6'd22, 64'h2222_3333_4444_5555);
      join
      chk("tie_host_at_2", 64'(last_host - t0), 64'd2);
      chk("tie_log_at_4", 64'(last_log - t0), 64'd4);
      do_host(1'b0, 6'd22, 64'd0);

      // 4: host sweeps 0..63 while the logger streams exchanges
      gap_en = 1'b1;
      fork
         for (int i = 0; i < 64; i++) do_host(1'b0, 6'(i), 64'd0);
         for (int k = 0; k < 16; k++) do_log(6'(32 + k), 64'hBEEF_0000_0000_0000 | 64'(k));
      join
      gap_en = 1'b0;
      chk("no_overrun_sweep", 64'(ov), 64'd0);

      // 5: starvation on the MAX_LOG_WAIT=2 instance
      chk("ov2_init", 64'(ov2), 64'd0);
      starve2(1'b0);
      repeat (3) begin @(negedge clk); chk("ov2_sticky", 64'(ov2), 64'd1); end
      @(posedge clk); #1; clr2 = 1'b1;
      @(posedge clk); #1; clr2 = 1'b0;
      @(negedge clk); chk("ov2_cleared", 64'(ov2), 64'd0);
      starve2(1'b1);

      // 6: reset in ST_ACC abandons a host write
      @(posedge clk); #1;
      acks0 = n_acks;
      host_req = 1'b1; host_we = 1'b1; host_ptr = 6'd50; host_data = 64'hDEAD;
      @(posedge clk); #3;
      chk("rst_acc_mem_en", 64'(men), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_outputs_zero", 64'(any_out), 64'd0);
      host_req = 1'b0; host_we = 1'b0;
      @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("no_strobe_after_reset", 64'(n_acks - acks0), 64'd0);
      @(posedge clk); #1;
      do_host(1'b0, 6'd50, 64'd0);

      repeat (3) @(negedge clk);
      chk("log_queue_drained", 64'(exp_log.size()), 64'd0);
      chk("host_queue_drained", 64'(exp_host.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
